// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with bubble insertion, EX operand forwarding and a sticky stall-run monitor.
// Optional perf counters (perf_bubbles_o / perf_flushes_o) are compiled in when PIPE_PERF_EN is defined.
module id_ex_stage #(
    parameter int DW        = 32,
    parameter int MAX_STALL = 4,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_stall_i,
    input  logic          id_flush_i,
    input  logic          id_wreg_i,
    input  logic          id_m2reg_i,
    input  logic          id_wmem_i,
    input  logic [3:0]    id_aluc_i,
    input  logic          id_shift_i,
    input  logic          id_aluimm_i,
    input  logic [DW-1:0] id_qa_i,
    input  logic [DW-1:0] id_qb_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [4:0]    id_sa_i,
    input  logic [4:0]    id_dest_i,
    input  logic [1:0]    fwda_i,
    input  logic [1:0]    fwdb_i,
    input  logic [DW-1:0] mem_alu_i,
    input  logic [DW-1:0] wb_data_i,
    output logic          ex_valid_o,
    output logic          ex_wreg_o,
    output logic          ex_m2reg_o,
    output logic          ex_wmem_o,
    output logic          ex_shift_o,
    output logic          ex_aluimm_o,
    output logic [3:0]    ex_aluc_o,
    output logic [4:0]    ex_dest_o,
    output logic [DW-1:0] ex_alu_a_o,
    output logic [DW-1:0] ex_alu_b_o,
    output logic [DW-1:0] ex_fwd_b_o,
`ifdef PIPE_PERF_EN
    output logic [CW-1:0] perf_bubbles_o,
    output logic [CW-1:0] perf_flushes_o,
`endif
    output logic          stall_err_o
);

    localparam int RW = $clog2(MAX_STALL + 2);
    localparam logic [RW-1:0] RUN_SAT = RW'(MAX_STALL + 1);

    logic          valid_q, valid_d;
    logic          wreg_q, wreg_d;
    logic          m2reg_q, m2reg_d;
    logic          wmem_q, wmem_d;
    logic          shift_q, shift_d;
    logic          aluimm_q, aluimm_d;
    logic [3:0]    aluc_q, aluc_d;
    logic [4:0]    dest_q, dest_d;
    logic [4:0]    sa_q, sa_d;
    logic [DW-1:0] qa_q, qa_d;
    logic [DW-1:0] qb_q, qb_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [RW-1:0] run_q, run_d;
    logic          err_q, err_d;
    logic          bubble;
    logic [DW-1:0] fwd_a, fwd_b;

    assign bubble = id_stall_i | id_flush_i;

    // A bubble clears every field so a squashed slot cannot leak stale operands.
    always_comb begin
        valid_d  = 1'b0;
        wreg_d   = 1'b0;
        m2reg_d  = 1'b0;
        wmem_d   = 1'b0;
        shift_d  = 1'b0;
        aluimm_d = 1'b0;
        aluc_d   = '0;
        dest_d   = '0;
        sa_d     = '0;
        qa_d     = '0;
        qb_d     = '0;
        imm_d    = '0;
        if (!bubble) begin
            valid_d  = 1'b1;
            wreg_d   = id_wreg_i;
            m2reg_d  = id_m2reg_i;
            wmem_d   = id_wmem_i;
            shift_d  = id_shift_i;
            aluimm_d = id_aluimm_i;
            aluc_d   = id_aluc_i;
            dest_d   = id_dest_i;
            sa_d     = id_sa_i;
            qa_d     = id_qa_i;
            qb_d     = id_qb_i;
            imm_d    = id_imm_i;
        end
    end

    always_comb begin
        run_d = '0;
        if (id_stall_i) begin
            run_d = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;
        end
        err_d = err_q | (run_d == RUN_SAT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            wreg_q   <= 1'b0;
            m2reg_q  <= 1'b0;
            wmem_q   <= 1'b0;
            shift_q  <= 1'b0;
            aluimm_q <= 1'b0;
            aluc_q   <= '0;
            dest_q   <= '0;
            sa_q     <= '0;
            qa_q     <= '0;
            qb_q     <= '0;
            imm_q    <= '0;
            run_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wreg_q   <= wreg_d;
            m2reg_q  <= m2reg_d;
            wmem_q   <= wmem_d;
            shift_q  <= shift_d;
            aluimm_q <= aluimm_d;
            aluc_q   <= aluc_d;
            dest_q   <= dest_d;
            sa_q     <= sa_d;
            qa_q     <= qa_d;
            qb_q     <= qb_d;
            imm_q    <= imm_d;
            run_q    <= run_d;
            err_q    <= err_d;
        end
    end

    // Forward selects are live from the hazard unit; code 11 falls back to the register value.
    always_comb begin
        case (fwda_i)
            2'b01:   fwd_a = mem_alu_i;
            2'b10:   fwd_a = wb_data_i;
            default: fwd_a = qa_q;
        endcase
        case (fwdb_i)
            2'b01:   fwd_b = mem_alu_i;
            2'b10:   fwd_b = wb_data_i;
            default: fwd_b = qb_q;
        endcase
    end

    assign ex_alu_a_o  = shift_q ? {{(DW-5){1'b0}}, sa_q} : fwd_a;
    assign ex_alu_b_o  = aluimm_q ? imm_q : fwd_b;
    assign ex_fwd_b_o  = fwd_b;
    assign ex_valid_o  = valid_q;
    assign ex_wreg_o   = wreg_q;
    assign ex_m2reg_o  = m2reg_q;
    assign ex_wmem_o   = wmem_q;
    assign ex_shift_o  = shift_q;
    assign ex_aluimm_o = aluimm_q;
    assign ex_aluc_o   = aluc_q;
    assign ex_dest_o   = dest_q;
    assign stall_err_o = err_q;

`ifdef PIPE_PERF_EN
    logic [CW-1:0] bub_q, bub_d;
    logic [CW-1:0] flu_q, flu_d;

    // A combined stall+flush is charged to the flush counter only.
    always_comb begin
        bub_d = bub_q;
        flu_d = flu_q;
        if (id_flush_i && (flu_q != '1)) begin
            flu_d = flu_q + 1'b1;
        end
        if (id_stall_i && !id_flush_i && (bub_q != '1)) begin
            bub_d = bub_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bub_q <= '0;
            flu_q <= '0;
        end else begin
            bub_q <= bub_d;
            flu_q <= flu_d;
        end
    end

    assign perf_bubbles_o = bub_q;
    assign perf_flushes_o = flu_q;
`endif

endmodule
